// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants for the IF sequencer and its PC mux.
// No logic; latency and backpressure are defined by the modules that import it.
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch bundle: hazard/redirect controls, instruction-memory port and IF/ID packet.
// master = fetch unit side; slave = pipeline/memory side that drives the controls.
interface if_fetch_unit_if;
    import if_pkg::*;

    logic            STALL;
    logic            REDIRECT;
    logic [XLEN-1:0] REDIRECT_PC;
    logic [XLEN-1:0] IMEM_ADDR;
    logic [XLEN-1:0] IMEM_INSTR;
    logic [XLEN-1:0] IF_PC;
    logic [XLEN-1:0] IF_INSTR;
    logic            IF_VALID;
    logic            IF_MISALIGN;

    modport master (
        input  STALL, REDIRECT, REDIRECT_PC, IMEM_INSTR,
        output IMEM_ADDR, IF_PC, IF_INSTR, IF_VALID, IF_MISALIGN
    );

    modport slave (
        output STALL, REDIRECT, REDIRECT_PC, IMEM_INSTR,
        input  IMEM_ADDR, IF_PC, IF_INSTR, IF_VALID, IF_MISALIGN
    );
endinterface

// File: rtl/if_pc_mux.sv
// Combinational next-pc_req select (reset > redirect > halt hold > +4 > hold) and IMEM_ADDR select.
// Zero latency; a stalled valid word re-reads its own address so the memory output stays put.
module if_pc_mux
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halted,
    input  logic            advance,
    input  logic            hold_addr,
    input  logic [XLEN-1:0] pc_req,
    input  logic [XLEN-1:0] resp_pc,
    output logic [XLEN-1:0] pc_req_nxt,
    output logic [XLEN-1:0] imem_addr
);

    always_comb begin
        pc_req_nxt = pc_req;
        if (reset) begin
            pc_req_nxt = RESET_PC;
        end else if (redirect) begin
            pc_req_nxt = redirect_pc;
        end else if (!halted && advance) begin
            pc_req_nxt = pc_req + PC_STEP;
        end
    end

    assign imem_addr = hold_addr ? resp_pc : pc_req;

endmodule

// File: rtl/if_fetch_unit.sv
// IF sequencer: owns the PC, one word/cycle from a 1-cycle registered IMEM; redirect costs one bubble.
// STALL holds the packet by replaying its address; FETCH_MISALIGN_TRAP_EN adds a HALT on misaligned redirects.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic           CLK,
    input  logic           RESET,
    if_fetch_unit_if.master fif
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc_req, pc_req_nxt;
    logic [XLEN-1:0] resp_pc, resp_pc_nxt;
    logic [XLEN-1:0] redirect_pc_eff;
    logic            redir_fault;
    logic            advance;
    logic            hold_addr;
    logic            halted;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_pc_eff = fif.REDIRECT_PC;
    assign redir_fault     = fif.REDIRECT && (fif.REDIRECT_PC[1:0] != 2'b00);
`else
    // Low bits are dropped so a sloppy target still lands on a word boundary.
    assign redirect_pc_eff = fif.REDIRECT_PC & ~32'h0000_0003;
    assign redir_fault     = 1'b0;
`endif

    assign halted    = (state == HALT);
    assign advance   = !fif.STALL || (state == BUBBLE);
    assign hold_addr = (state == RUN) && fif.STALL;

    if_pc_mux #(.RESET_PC(RESET_PC)) u_pc_mux (
        .reset       (RESET),
        .redirect    (fif.REDIRECT),
        .redirect_pc (redirect_pc_eff),
        .halted      (halted),
        .advance     (advance),
        .hold_addr   (hold_addr),
        .pc_req      (pc_req),
        .resp_pc     (resp_pc),
        .pc_req_nxt  (pc_req_nxt),
        .imem_addr   (fif.IMEM_ADDR)
    );

    always_ff @(posedge CLK) begin
        state   <= state_nxt;
        pc_req  <= pc_req_nxt;
        resp_pc <= resp_pc_nxt;
    end

    always_comb begin
        state_nxt   = state;
        resp_pc_nxt = resp_pc;
        if (RESET) begin
            state_nxt   = BUBBLE;
            resp_pc_nxt = '0;
        end else if (fif.REDIRECT) begin
            // The word landing at this edge is wrong-path; BUBBLE discards it.
            if (redir_fault) begin
                state_nxt   = HALT;
                resp_pc_nxt = redirect_pc_eff;
            end else begin
                state_nxt   = BUBBLE;
            end
        end else if (!halted && advance) begin
            state_nxt   = RUN;
            resp_pc_nxt = pc_req;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            misalign <= 1'b0;
        end else if (fif.REDIRECT) begin
            misalign <= redir_fault;
        end
    end

    assign fif.IF_MISALIGN = misalign;
`else
    assign fif.IF_MISALIGN = 1'b0;
`endif

    assign fif.IF_VALID = (state == RUN);
    assign fif.IF_PC    = resp_pc;
    assign fif.IF_INSTR = fif.IMEM_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed fetch scenarios then random stall/redirect/reset traffic,
// all compared against an instruction-stream reference model and a registered memory model.
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic CLK;
    logic RESET;
    logic [31:0] imem_q;
    int checks = 0;
    int errors = 0;

    // reference model: the stream the IF/ID register should see
    logic        m_known = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_mis   = 1'b0;
    logic        m_halt  = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_next  = '0;

    if_fetch_unit_if fif ();

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .fif   (fif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd16) return ((a >> 2) + 32'd1) * 32'h11;
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge CLK) begin
        if (RESET) imem_q <= '0;
        else       imem_q <= mem_word(fif.IMEM_ADDR);
    end
    assign fif.IMEM_INSTR = imem_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
        RESET           = rst;
        fif.STALL       = st;
        fif.REDIRECT    = rd;
        fif.REDIRECT_PC = rpc;
        #1;
        if (m_known) chk("imem_addr", fif.IMEM_ADDR, (m_valid && st) ? m_pc : m_next);
        @(posedge CLK);
        if (rst) begin
            m_valid = 1'b0; m_pc = '0; m_next = RESET_PC; m_mis = 1'b0; m_halt = 1'b0;
            m_known = 1'b1;
        end else if (rd) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin
                m_halt = 1'b1; m_mis = 1'b1; m_valid = 1'b0; m_pc = rpc; m_next = rpc;
            end else begin
                m_halt = 1'b0; m_mis = 1'b0; m_valid = 1'b0; m_next = rpc;
            end
`else
            m_valid = 1'b0;
            m_next  = rpc & ~32'h3;
`endif
        end else if (!m_halt && (!m_valid || !st)) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
        end
        #1;
        chk("if_valid", {31'b0, fif.IF_VALID}, {31'b0, m_valid});
        chk("if_pc", fif.IF_PC, m_pc);
        chk("if_misalign", {31'b0, fif.IF_MISALIGN}, {31'b0, m_mis});
        if (m_valid) chk("if_instr", fif.IF_INSTR, mem_word(m_pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; fif.STALL = 1'b0; fif.REDIRECT = 1'b0; fif.REDIRECT_PC = '0;

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_instr", fif.IF_INSTR, 32'h0);
        chk("rst_addr", fif.IMEM_ADDR, RESET_PC);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            chk("seq_pc", fif.IF_PC, 32'(i * 4));
            chk("seq_instr", fif.IF_INSTR, 32'((i + 1) * 32'h11));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("stall_pc", fif.IF_PC, 32'h8);
            chk("stall_instr", fif.IF_INSTR, 32'h33);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("release_pc", fif.IF_PC, 32'hC);
        chk("release_instr", fif.IF_INSTR, 32'h44);

        step(1'b0, 1'b0, 1'b1, 32'h40);
        chk("redir_bubble", {31'b0, fif.IF_VALID}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_target", fif.IF_PC, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_next", fif.IF_PC, 32'h44);

        step(1'b0, 1'b1, 1'b1, 32'h80);
        chk("redir_stall_bubble", {31'b0, fif.IF_VALID}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("bubble_fill_pc", fif.IF_PC, 32'h80);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("fill_release_pc", fif.IF_PC, 32'h84);

        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_top", fif.IF_PC, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_zero", fif.IF_PC, 32'h0);

        step(1'b0, 1'b0, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("halt_misalign", {31'b0, fif.IF_MISALIGN}, 32'h1);
        step(1'b0, 1'b0, 1'b1, 32'h100);
`endif
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("misalign_target", fif.IF_PC, 32'h100);

        step(1'b0, 1'b0, 1'b1, 32'h300);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        chk("mid_reset_pc", fif.IF_PC, 32'h0);
        chk("mid_reset_valid", {31'b0, fif.IF_VALID}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic        r_rst, r_st, r_rd;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 49) == 0);
            r_st  = ($urandom_range(0, 9) < 3);
            r_rd  = ($urandom_range(0, 9) == 0);
            r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                 : 32'($urandom_range(0, 4095));
            step(r_rst, r_st, r_rd, r_pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
